aes128_key_sched: RTL
=====================

AES128_KEY_SCHED -- requirements
Module: aes128_key_sched

Interface
REQ-001 SHALL have parameter SBOX_LATENCY, default 3: fixed cycle latency of the external pipelined S-box stage; legal range 1..7.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port key_i, input, 128: cipher key; byte 0 = key_i[127:120]; w0 = key_i[127:96], w3 = key_i[31:0].
REQ-005 SHALL have port start_i, input, 1: request to expand key_i.
REQ-006 SHALL have port busy_o, output, 1: expansion in progress.
REQ-007 SHALL have port sbox_in_o, output, 32: 4 bytes to the external S-box.
REQ-008 SHALL have port sbox_out_i, input, 32: byte-wise S-box of sbox_in_o, delayed SBOX_LATENCY cycles.
REQ-009 SHALL have port rk_o, output, 128: current round key, same byte order as key_i.
REQ-010 SHALL have port rk_idx_o, output, 4: round index 0..10 of rk_o.
REQ-011 SHALL have port rk_valid_o, output, 1: one-cycle pulse when rk_o/rk_idx_o hold a new round key.
REQ-012 SHALL have port done_o, output, 1: one-cycle pulse coincident with the rk_valid_o for round 10.

Function
REQ-013 SHALL implement FSM states IDLE, SUB, COMB.
REQ-014 IDLE with start_i=1 SHALL latch key_i into the key register, set rk_idx_o=0, set rcon=0x01, and pulse rk_valid_o next cycle (start cycle t -> rk0 valid at t+1); then enter SUB.
REQ-015 start_i SHALL be ignored outside IDLE; no queuing.
REQ-016 sbox_in_o SHALL be driven combinationally from the key register as RotWord(w3) = {w3[23:0], w3[31:24]}.
REQ-017 SUB SHALL count SBOX_LATENCY-1 cycles with a wait counter, then go to COMB; sbox_in_o stays stable for the whole SUB+COMB window.
REQ-018 COMB SHALL sample sbox_out_i, form t = sbox_out_i ^ {rcon, 24'h0}, and register w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2', increment rk_idx_o, and pulse rk_valid_o in the following cycle.
REQ-019 Consecutive rk_valid_o pulses SHALL be exactly SBOX_LATENCY+1 cycles apart; with default parameter rk10 SHALL be valid at t+41.
REQ-020 rcon SHALL update after each COMB by GF(2^8) xtime (shift left, XOR 0x1B on carry), giving 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-021 After the COMB producing round 10, the FSM SHALL return to IDLE and pulse done_o with rk_valid_o.
REQ-022 busy_o SHALL be 1 from t+1 up to and including the round-10 valid cycle, and 0 otherwise.
REQ-023 rk_o and rk_idx_o SHALL hold their last values in IDLE until the next start.
REQ-024 start_i=1 in the same cycle as done_o SHALL be accepted, because the FSM is IDLE in that cycle; the new rk0 is valid in the next cycle.
REQ-025 No combinational path SHALL exist from sbox_out_i or start_i to any output.

Reset
REQ-026 rst_i=1 SHALL force IDLE, with busy_o=0, rk_valid_o=0, done_o=0, rk_o=0, rk_idx_o=0, rcon=0x01, and wait counter=0.
REQ-027 rst_i SHALL take priority over start_i and SHALL abort an expansion mid-operation with no further rk_valid_o pulses.
REQ-028 In-flight S-box results arriving after reset SHALL be ignored.

Verification
REQ-029 Bench SHALL cover these cases, using a behavioural S-box model with latency SBOX_LATENCY:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+41 with done_o=1.
- All-zero key -> rk1 = 62636363626363636263636362636363; rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start_i held high for 50 cycles -> exactly one expansion, then a second accepted in the done_o cycle; its rk0 appears at done+1.
- rst_i asserted when rk_idx_o=5 -> all outputs 0 next cycle; no pulses afterward; a fresh start yields correct rk1..rk10.
- SBOX_LATENCY=1 and 7 -> valid spacing 2 and 8 cycles respectively, with identical round keys.
- key_i changed while busy -> round keys unaffected, still those of the latched key.

Source files
------------

// File: rtl/aes128_key_sched.sv
// AES-128 key expansion: emits round keys 0..10 one at a time, sharing an
// external pipelined S-box of fixed latency SBOX_LATENCY (1..7).
module aes128_key_sched #(
    parameter int unsigned SBOX_LATENCY = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [127:0] key_i,
    input  logic         start_i,
    output logic         busy_o,
    output logic [31:0]  sbox_in_o,
    input  logic [31:0]  sbox_out_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx_o,
    output logic         rk_valid_o,
    output logic         done_o
);

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned LAST_RND = 9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] COMB = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_n;
    logic [7:0]       rcon;
    logic [7:0]       rcon_n;
    logic [127:0]     rk_n;
    logic [3:0]       idx_n;
    logic             valid_n;
    logic             done_n;
    logic             busy_n;
    logic [31:0]      t_word;
    logic [31:0]      nw0;
    logic [31:0]      nw1;
    logic [31:0]      nw2;
    logic [31:0]      nw3;

    // RotWord(w3) stays stable from the key register for the whole SUB+COMB window
    assign sbox_in_o = {rk_o[23:0], rk_o[31:24]};

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        rcon_n     = rcon;
        rk_n       = rk_o;
        idx_n      = rk_idx_o;
        valid_n    = 1'b0;
        done_n     = 1'b0;
        busy_n     = (state != IDLE);

        t_word = sbox_out_i ^ {rcon, 24'h000000};
        nw0    = rk_o[127:96] ^ t_word;
        nw1    = rk_o[95:64]  ^ nw0;
        nw2    = rk_o[63:32]  ^ nw1;
        nw3    = rk_o[31:0]   ^ nw2;

        case (state)
            IDLE: begin
                if (start_i) begin
                    rk_n       = key_i;
                    idx_n      = 4'd0;
                    rcon_n     = 8'h01;
                    wait_cnt_n = '0;
                    valid_n    = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = SUB;
                end
            end
            SUB: begin
                // wait for the S-box result of the current RotWord to emerge
                if (wait_cnt == CNT_W'(SBOX_LATENCY - 1)) begin
                    wait_cnt_n = '0;
                    state_n    = COMB;
                end else begin
                    wait_cnt_n = CNT_W'(wait_cnt + 1'b1);
                end
            end
            COMB: begin
                rk_n    = {nw0, nw1, nw2, nw3};
                idx_n   = 4'(rk_idx_o + 4'd1);
                rcon_n  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                valid_n = 1'b1;
                if (rk_idx_o == 4'(LAST_RND)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = SUB;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rcon       <= 8'h01;
            rk_o       <= '0;
            rk_idx_o   <= 4'd0;
            rk_valid_o <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            rcon       <= rcon_n;
            rk_o       <= rk_n;
            rk_idx_o   <= idx_n;
            rk_valid_o <= valid_n;
            done_o     <= done_n;
            busy_o     <= busy_n;
        end
    end

endmodule
